// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture down-sampler: storage formats,
// controller states and RGB565 field layout.
package cam_pkg;

  localparam logic [1:0] FMT_RGB332 = 2'd0;
  localparam logic [1:0] FMT_RGB444 = 2'd1;
  localparam logic [1:0] FMT_GRAY   = 2'd2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  // Bit positions inside the assembled {hi, lo} RGB565 word.
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/cam_pix_convert.sv
// Combinational RGB565 -> RGB332 / RGB444 / gray converter; result is
// right-aligned in DW bits with zero padding.
module cam_pix_convert
  import cam_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [7:0]    hi_i,
  input  logic [7:0]    lo_i,
  input  logic [1:0]    fmt_i,
  output logic [DW-1:0] pix_o
);

  logic [15:0] word;
  rgb565_t     px;
  logic [7:0]  gray;
  logic [11:0] res;

  assign word = {hi_i, lo_i};
  assign px.r = word[R_MSB:R_LSB];
  assign px.g = word[G_MSB:G_LSB];
  assign px.b = word[B_MSB:B_LSB];

  // 2R + 2G + B peaks at 219, so 8 bits never overflow.
  assign gray = {2'b00, px.r, 1'b0} + {1'b0, px.g, 1'b0} + {3'b000, px.b};

  always_comb begin
    res = '0;
    case (fmt_i)
      FMT_RGB332: res = {4'b0000, px.r[4:2], px.g[5:3], px.b[4:3]};
      FMT_RGB444: res = {px.r[4:1], px.g[5:2], px.b[4:1]};
      FMT_GRAY:   res = {4'b0000, gray};
      default:    res = '0;
    endcase
  end

  assign pix_o = DW'(res);

endmodule

// File: rtl/cam_capture_ds.sv
// OV7670 capture path: byte pairing, format conversion, 1/2 decimation and
// bounded frame-buffer addressing. CAM_CAPTURE_STATS_EN adds line statistics.
//
// state      | meaning
// ST_IDLE    | waiting for enable with VSync high
// ST_ARMED   | armed, waiting for VSync to fall
// ST_CAPTURE | frame active, ends on VSync rising
module cam_capture_ds
  import cam_pkg::*;
#(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int AW      = 15,
  parameter int DW      = 8,
  parameter int PIX_FMT = 0,
  parameter int DECIM   = 1
) (
  input  logic          Pclk,
  input  logic          rst_n,
  input  logic [7:0]    data_bus,
  input  logic          Href,
  input  logic          VSync,
  input  logic          enable,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          frame_done,
  output logic          overflow
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [9:0]    line_cnt,
  output logic [9:0]    last_line_px,
  output logic          short_line
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

  logic [1:0]    state_q, state_d;
  logic          vs_q;
  logic          href_q, href_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic [9:0]    px_cnt_q, px_cnt_d;
  logic [9:0]    line_q, line_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          full_q, full_d;
  logic          regw_q, regw_d;
  logic [AW-1:0] addr_out_q, addr_out_d;
  logic [DW-1:0] data_q, data_d;
  logic          fdone_q, fdone_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0] pix_conv;
  logic          arm_to_cap;
  logic          line_end;
  logic          line_kept;
  logic          keep;

  cam_pix_convert #(.DW(DW)) u_conv (
    .hi_i  (hi_q),
    .lo_i  (data_bus),
    .fmt_i (2'(PIX_FMT)),
    .pix_o (pix_conv)
  );

  assign arm_to_cap = (state_q == ST_ARMED) && vs_q && !VSync;
  assign line_end   = (state_q == ST_CAPTURE) && !VSync && !Href && href_q;
  assign line_kept  = (DECIM != 2) || !line_q[0];
  assign keep       = line_kept && ((DECIM != 2) || !px_cnt_q[0]);

  always_comb begin
    state_d    = state_q;
    href_d     = Href;
    phase_d    = phase_q;
    hi_d       = hi_q;
    px_cnt_d   = px_cnt_q;
    line_d     = line_q;
    addr_d     = addr_q;
    full_d     = full_q;
    regw_d     = 1'b0;
    addr_out_d = addr_out_q;
    data_d     = data_q;
    fdone_d    = 1'b0;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE:    if (enable && VSync) state_d = ST_ARMED;
      ST_ARMED:   if (arm_to_cap) begin
                    state_d = ST_CAPTURE;
                    ovf_d   = 1'b0;
                  end
      ST_CAPTURE: if (!vs_q && VSync) begin
                    state_d = ST_IDLE;
                    fdone_d = 1'b1;
                  end
      default:    state_d = ST_IDLE;
    endcase

    // VSync wins over Href: frame-level counters restart and nothing is written.
    if (VSync) begin
      href_d   = 1'b0;
      phase_d  = 1'b0;
      px_cnt_d = '0;
      line_d   = '0;
      addr_d   = '0;
      full_d   = 1'b0;
    end else if (state_q == ST_CAPTURE) begin
      if (Href) begin
        if (!phase_q) begin
          hi_d    = data_bus;
          phase_d = 1'b1;
        end else begin
          phase_d  = 1'b0;
          px_cnt_d = px_cnt_q + 10'd1;
          if (keep) begin
            if (full_q) begin
              ovf_d = 1'b1;
            end else begin
              regw_d     = 1'b1;
              addr_out_d = addr_q;
              data_d     = pix_conv;
              if (addr_q == LAST_ADDR) full_d = 1'b1;
              else                     addr_d = addr_q + AW'(1);
            end
          end
        end
      end else begin
        phase_d = 1'b0;
        if (line_end) begin
          line_d   = line_q + 10'd1;
          px_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vs_q       <= 1'b0;
      href_q     <= 1'b0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      px_cnt_q   <= '0;
      line_q     <= '0;
      addr_q     <= '0;
      full_q     <= 1'b0;
      regw_q     <= 1'b0;
      addr_out_q <= '0;
      data_q     <= '0;
      fdone_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= VSync;
      href_q     <= href_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      px_cnt_q   <= px_cnt_d;
      line_q     <= line_d;
      addr_q     <= addr_d;
      full_q     <= full_d;
      regw_q     <= regw_d;
      addr_out_q <= addr_out_d;
      data_q     <= data_d;
      fdone_q    <= fdone_d;
      ovf_q      <= ovf_d;
    end
  end

  assign DP_RAM_regW    = regw_q;
  assign DP_RAM_addr_in = addr_out_q;
  assign DP_RAM_data_in = data_q;
  assign frame_done     = fdone_q;
  assign overflow       = ovf_q;

`ifdef CAM_CAPTURE_STATS_EN
  logic [9:0] last_px_q, last_px_d;
  logic [9:0] kept_px;
  logic       short_q, short_d;

  always_comb begin
    last_px_d = last_px_q;
    short_d   = short_q;
    kept_px   = (DECIM == 2) ? ((px_cnt_q + 10'd1) >> 1) : px_cnt_q;
    if (arm_to_cap) short_d = 1'b0;
    if (line_end) begin
      last_px_d = px_cnt_q;
      if (line_kept && (int'(kept_px) < IMG_W)) short_d = 1'b1;
    end
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      last_px_q <= '0;
      short_q   <= 1'b0;
    end else begin
      last_px_q <= last_px_d;
      short_q   <= short_d;
    end
  end

  assign line_cnt     = line_q;
  assign last_line_px = last_px_q;
  assign short_line   = short_q;
`endif

endmodule

// File: tb/tb_cam_capture_ds.sv
// Directed bench for cam_capture_ds: five parameter variants share one camera bus.
module tb_cam_capture_ds;

  logic       Pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_bus = 8'h00;
  logic       Href = 1'b0;
  logic       VSync = 1'b0;
  logic       enable = 1'b1;

  always #5 Pclk = ~Pclk;

  logic        w0, w1, w2, w3, w4;
  logic [14:0] a0, a1, a2, a3, a4;
  logic [7:0]  d0, d1, d3, d4;
  logic [11:0] d2;
  logic        f0, f1, f2, f3, f4;
  logic        o0, o1, o2, o3, o4;

  // u0: RGB332 4x2; u1: gray; u2: RGB444 in 12 bits; u3: decimate by 2; u4: 2x2 buffer
  cam_capture_ds #(.IMG_W(4), .IMG_H(2), .AW(15), .DW(8), .PIX_FMT(0), .DECIM(1)) u0 (
    .Pclk(Pclk), .rst_n(rst_n), .data_bus(data_bus), .Href(Href), .VSync(VSync), .enable(enable),
    .DP_RAM_regW(w0), .DP_RAM_addr_in(a0), .DP_RAM_data_in(d0), .frame_done(f0), .overflow(o0));
  cam_capture_ds #(.IMG_W(4), .IMG_H(2), .AW(15), .DW(8), .PIX_FMT(2), .DECIM(1)) u1 (
    .Pclk(Pclk), .rst_n(rst_n), .data_bus(data_bus), .Href(Href), .VSync(VSync), .enable(enable),
    .DP_RAM_regW(w1), .DP_RAM_addr_in(a1), .DP_RAM_data_in(d1), .frame_done(f1), .overflow(o1));
  cam_capture_ds #(.IMG_W(4), .IMG_H(2), .AW(15), .DW(12), .PIX_FMT(1), .DECIM(1)) u2 (
    .Pclk(Pclk), .rst_n(rst_n), .data_bus(data_bus), .Href(Href), .VSync(VSync), .enable(enable),
    .DP_RAM_regW(w2), .DP_RAM_addr_in(a2), .DP_RAM_data_in(d2), .frame_done(f2), .overflow(o2));
  cam_capture_ds #(.IMG_W(4), .IMG_H(2), .AW(15), .DW(8), .PIX_FMT(0), .DECIM(2)) u3 (
    .Pclk(Pclk), .rst_n(rst_n), .data_bus(data_bus), .Href(Href), .VSync(VSync), .enable(enable),
    .DP_RAM_regW(w3), .DP_RAM_addr_in(a3), .DP_RAM_data_in(d3), .frame_done(f3), .overflow(o3));
  cam_capture_ds #(.IMG_W(2), .IMG_H(2), .AW(15), .DW(8), .PIX_FMT(0), .DECIM(1)) u4 (
    .Pclk(Pclk), .rst_n(rst_n), .data_bus(data_bus), .Href(Href), .VSync(VSync), .enable(enable),
    .DP_RAM_regW(w4), .DP_RAM_addr_in(a4), .DP_RAM_data_in(d4), .frame_done(f4), .overflow(o4));

  // Write monitors
  logic [14:0] wa0 [256];
  logic [7:0]  wd0 [256];
  logic [14:0] wa3 [256];
  logic [7:0]  wd3 [256];
  int n0 = 0, n1 = 0, n2 = 0, n3 = 0, n4 = 0, fd0 = 0, fdo = 0;
  logic [14:0] la1 = '0, la2 = '0, la4 = '0;
  logic [7:0]  ld1 = '0, ld4 = '0;
  logic [11:0] ld2 = '0;

  always @(negedge Pclk) begin
    if (w0) begin wa0[n0 % 256] <= a0; wd0[n0 % 256] <= d0; n0 <= n0 + 1; end
    if (w1) begin la1 <= a1; ld1 <= d1; n1 <= n1 + 1; end
    if (w2) begin la2 <= a2; ld2 <= d2; n2 <= n2 + 1; end
    if (w3) begin wa3[n3 % 256] <= a3; wd3[n3 % 256] <= d3; n3 <= n3 + 1; end
    if (w4) begin la4 <= a4; ld4 <= d4; n4 <= n4 + 1; end
    if (f0) fd0 <= fd0 + 1;
    fdo <= fdo + int'(f1) + int'(f2) + int'(f3) + int'(f4);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic h, input logic v);
    @(negedge Pclk);
    data_bus = b;
    Href = h;
    VSync = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b1);
    idle(2);
  endtask

  // pattern=1: hi = {line[2:0], 2'b00, px[2:0]}, lo = 0, so RGB332 = {line, px, 2'b00}
  task automatic send_frame(input int nl, input int np, input logic pattern,
                            input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] h;
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < np; p++) begin
        h = pattern ? {l[2:0], 2'b00, p[2:0]} : hi;
        drive(h, 1'b1, 1'b0);
        drive(pattern ? 8'h00 : lo, 1'b1, 1'b0);
      end
      idle(2);
    end
  endtask

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [7:0]  e332;
    logic [7:0]  egray;
    logic [11:0] e444;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int b0, b1, b2, b3, b4, bf0, bfo;
    logic [7:0] exp_d;

    vecs[0] = '{8'hF8, 8'h00, 8'hE0, 8'h3E, 12'hF00};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hDB, 12'hFFF};
    vecs[2] = '{8'h07, 8'hE0, 8'h1C, 8'h7E, 12'h0F0};
    vecs[3] = '{8'h00, 8'h1F, 8'h03, 8'h1F, 12'h00F};
    vecs[4] = '{8'h84, 8'h10, 8'h92, 8'h70, 12'h888};

    repeat (3) @(negedge Pclk);
    chk("rst_regW", {31'b0, w0}, 0);
    chk("rst_addr", {17'b0, a0}, 0);
    chk("rst_data", {24'b0, d0}, 0);
    chk("rst_fdone", {31'b0, f0}, 0);
    chk("rst_ovf", {31'b0, o0}, 0);
    rst_n = 1'b1;
    idle(2);
    vsync_pulse();

    for (int v = 0; v < 5; v++) begin
      b0 = n0; b1 = n1; b2 = n2; b3 = n3; b4 = n4; bf0 = fd0; bfo = fdo;
      send_frame(2, 4, 1'b0, vecs[v].hi, vecs[v].lo);
      idle(2);
      chk("u4_ovf_set", {31'b0, o4}, 1);
      chk("u0_ovf_clear", {31'b0, o0}, 0);
      vsync_pulse();
      chk("u4_ovf_cleared", {31'b0, o4}, 0);
      chk("u0_wr_count", n0 - b0, 8);
      for (int i = 0; i < 8; i++) begin
        chk("u0_addr", {17'b0, wa0[(b0 + i) % 256]}, i);
        chk("u0_data", {24'b0, wd0[(b0 + i) % 256]}, {24'b0, vecs[v].e332});
      end
      chk("u1_count", n1 - b1, 8);
      chk("u1_gray", {24'b0, ld1}, {24'b0, vecs[v].egray});
      chk("u1_last_addr", {17'b0, la1}, 7);
      chk("u1_ovf", {31'b0, o1}, 0);
      chk("u2_count", n2 - b2, 8);
      chk("u2_rgb444", {20'b0, ld2}, {20'b0, vecs[v].e444});
      chk("u2_last_addr", {17'b0, la2}, 7);
      chk("u2_ovf", {31'b0, o2}, 0);
      chk("u3_count", n3 - b3, 2);
      chk("u4_count", n4 - b4, 4);
      chk("u4_last_addr", {17'b0, la4}, 3);
      chk("u4_last_data", {24'b0, ld4}, {24'b0, vecs[v].e332});
      chk("u0_frame_done", fd0 - bf0, 1);
      chk("others_frame_done", fdo - bfo, 4);
    end

    // Decimation: 4 lines x 8 pixels, only even lines / even positions kept
    b0 = n0; b3 = n3;
    send_frame(4, 8, 1'b1, 8'h00, 8'h00);
    idle(2);
    chk("u3_dec_count", n3 - b3, 8);
    for (int i = 0; i < 8; i++) begin
      int l, p;
      l = (i / 4) * 2;
      p = (i % 4) * 2;
      exp_d = {l[2:0], p[2:0], 2'b00};
      chk("u3_dec_addr", {17'b0, wa3[(b3 + i) % 256]}, i);
      chk("u3_dec_data", {24'b0, wd3[(b3 + i) % 256]}, {24'b0, exp_d});
    end
    chk("u3_dec_ovf", {31'b0, o3}, 0);
    chk("u0_full_count", n0 - b0, 8);
    chk("u0_full_ovf", {31'b0, o0}, 1);
    vsync_pulse();

    // Odd trailing byte dropped, then VSync pulsed in the middle of a line
    b0 = n0; bf0 = fd0;
    drive(8'hF8, 1'b1, 1'b0);
    drive(8'h00, 1'b1, 1'b0);
    drive(8'hF8, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h07, 1'b1, 1'b0);
    drive(8'hE0, 1'b1, 1'b1);
    drive(8'hE0, 1'b1, 1'b1);
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h07, 1'b1, 1'b0);
    drive(8'hE0, 1'b1, 1'b0);
    idle(3);
    chk("odd_wr_count", n0 - b0, 2);
    chk("odd_addr0", {17'b0, wa0[b0 % 256]}, 0);
    chk("odd_data0", {24'b0, wd0[b0 % 256]}, 32'hE0);
    chk("midvs_addr", {17'b0, wa0[(b0 + 1) % 256]}, 0);
    chk("midvs_data", {24'b0, wd0[(b0 + 1) % 256]}, 32'h1C);
    chk("midvs_frame_done", fd0 - bf0, 1);
    vsync_pulse();

    // Asynchronous reset in the middle of a line
    for (int i = 0; i < 3; i++) begin
      drive(8'hF8, 1'b1, 1'b0);
      drive(8'h00, 1'b1, 1'b0);
    end
    @(posedge Pclk);
    #2;
    chk("pre_rst_regW", {31'b0, w0}, 1);
    chk("pre_rst_addr", {17'b0, a0}, 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_regW", {31'b0, w0}, 0);
    chk("async_rst_addr", {17'b0, a0}, 0);
    chk("async_rst_data", {24'b0, d0}, 0);
    chk("async_rst_ovf", {31'b0, o0}, 0);
    enable = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    b0 = n0; bf0 = fd0;
    vsync_pulse();
    send_frame(2, 4, 1'b0, 8'hF8, 8'h00);
    vsync_pulse();
    chk("disabled_writes", n0 - b0, 0);
    chk("disabled_frame_done", fd0 - bf0, 0);

    enable = 1'b1;
    b0 = n0; bf0 = fd0;
    vsync_pulse();
    send_frame(2, 4, 1'b0, 8'hF8, 8'h00);
    vsync_pulse();
    chk("rearm_writes", n0 - b0, 8);
    chk("rearm_frame_done", fd0 - bf0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_capture_ds.md
# cam_capture_ds

Parametrised camera capture down-sampler, successor to the fixed RGB565→RGB332 capture path. It sits between the OV7670 parallel pixel bus (Pclk domain) and the frame-buffer dual-port RAM write port. It assembles two-byte RGB565 pixels and converts them to a selectable storage format. It decimates by 1 or 2 in both axes and writes one RAM word per kept pixel, with frame sequencing, bounded addressing and a frame-done pulse.

## Interface
Parameters:
- IMG_W, 160: kept pixels per line after decimation.
- IMG_H, 120: kept lines per frame after decimation.
- AW, 15: RAM address width; IMG_W*IMG_H ≤ 2**AW.
- DW, 8: RAM data width; must be ≥12 when PIX_FMT=1.
- PIX_FMT, 0: storage format. 0 = RGB332, 1 = RGB444, 2 = 8-bit gray. The result is right-aligned in DW with zero padding.
- DECIM, 1: decimation factor, 1 or 2.

Ports:
- Pclk  in  1  camera pixel clock; sole clock.
- rst_n  in  1  asynchronous active-low reset.
- data_bus  in  8  camera byte bus.
- Href  in  1  line valid.
- VSync  in  1  frame sync, active high.
- enable  in  1  arm capture of the next frame.
- DP_RAM_regW  out  1  write strobe, one Pclk per pixel.
- DP_RAM_addr_in  out  AW  write address.
- DP_RAM_data_in  out  DW  converted pixel.
- frame_done  out  1  one-cycle pulse at the end of a captured frame.
- overflow  out  1  sticky per frame; set when a kept pixel arrives after the buffer is full.

## Operation
- FSM states: IDLE, ARMED, CAPTURE.
  - IDLE → ARMED when enable=1 and VSync=1.
  - ARMED → CAPTURE on VSync falling edge.
  - CAPTURE → IDLE on VSync rising edge. frame_done pulses on that transition.
  - enable is checked only in IDLE. Dropping enable mid-frame does not abort the frame.
- VSync=1 in any state clears the address counter, byte phase, pixel and line counters, and the Href history. overflow clears on the ARMED→CAPTURE transition.
- Byte phase (CAPTURE, Href=1):
  - phase 0 latches the high byte hi = {R[4:0], G[5:3]}.
  - phase 1 takes the low byte lo = {G[2:0], B[4:0]} and forms the pixel.
  - Phase clears whenever Href=0. An odd trailing byte is dropped.
- Conversion:
  - RGB332 = {R[4:2], G[5:3], B[4:3]}.
  - RGB444 = {R[4:1], G[5:2], B[4:1]}.
  - gray = 2R + 2G + B, computed in 8 bits (maximum 219, no overflow).
- Decimation:
  - With DECIM=2, keep pixels with even in-line index and lines with even line index.
  - Line index increments on the Href falling edge.
  - Dropped pixels generate no write.
- Addressing:
  - Address starts at 0 each frame and increments after each write.
  - The write at address IMG_W*IMG_H-1 is the last one. Later kept pixels are discarded and set overflow. There is no wrap.
- Lines longer than IMG_W are not truncated per line; only the frame bound applies.

## Timing
- Reset values: DP_RAM_regW=0, DP_RAM_addr_in=0, DP_RAM_data_in=0, frame_done=0, overflow=0, FSM=IDLE, phase=0.
- All outputs are registered.
- Pixel latency: high byte sampled at Pclk edge k, low byte at edge k+1. DP_RAM_regW, addr and data are valid in the cycle after edge k+1 for exactly one cycle.
- Writes are at most one every 2 Pclk (DECIM=1) or one every 4 Pclk (DECIM=2).
- frame_done is asserted in the cycle after the edge that samples VSync rising in CAPTURE.
- VSync=1 and Href=1 in the same cycle: VSync wins; no write.
- rst_n low mid-frame immediately forces the reset values. After release, the block waits in IDLE and needs a full VSync to re-arm.

## Configuration
- CAM_CAPTURE_STATS_EN defined: adds outputs line_cnt[9:0] and last_line_px[9:0], plus sticky short_line.
  - line_cnt counts raw Href lines this frame.
  - last_line_px holds the raw pixel count of the last completed line.
  - short_line is set when a completed kept line has fewer than IMG_W kept pixels; it clears with overflow.
- Not defined: these ports and counters are absent. Core behaviour is identical.

## Structure
- Shared package cam_pkg holds:
  - the PIX_FMT encodings (FMT_RGB332, FMT_RGB444, FMT_GRAY);
  - the FSM state constants;
  - the RGB565 field positions.
- One sub-module: cam_pix_convert, combinational. Inputs are hi/lo bytes and PIX_FMT; output is DW bits.

## Test plan
- Reset, enable=1, one VSync, then a 2-line × 4-pixel frame with pixel bytes 0xF8,0x00 (pure red), PIX_FMT=0, IMG_W=4, IMG_H=2. Expect 8 writes, addr 0..7, data 0xE0, then frame_done after VSync rises.
- PIX_FMT=2, bytes 0xFF,0xFF. Expect data 0xDB (219). PIX_FMT=1, DW=12, bytes 0x07,0xE0. Expect 0x0F0.
- DECIM=2, 4 lines × 8 pixels, IMG_W=4, IMG_H=2. Expect 8 writes containing only pixels from even lines at even positions.
- IMG_W*IMG_H=4 with 6 pixels sent. Expect writes at addr 0..3 only and overflow=1. overflow clears at the next frame start.
- Href drops after 3 bytes, and VSync is pulsed mid-line. Expect the odd byte dropped, no spurious write, and address reset to 0.
- rst_n low mid-line. Expect outputs at reset values immediately. With enable=0 at the next VSync, expect no writes and no frame_done.
